// File: rtl/inst_pkg.sv
// rtl/inst_pkg.sv - RV32I opcode constants and instruction format enum
// Shared by the encoder, decoder and control logic.
package inst_pkg;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_ILL
  } fmt_t;

  function automatic fmt_t fmt_of(input logic [6:0] op);
    case (op)
      OP_REG:                              return FMT_R;
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: return FMT_I;
      OP_STORE:                            return FMT_S;
      OP_BRANCH:                           return FMT_B;
      OP_LUI, OP_AUIPC:                    return FMT_U;
      OP_JAL:                              return FMT_J;
      default:                             return FMT_ILL;
    endcase
  endfunction

endpackage

// File: rtl/inst_pack.sv
// rtl/inst_pack.sv - combinational RV32I field packer (fmt, word, imm_ok)
// Range checking of the immediate is built only with INST_ENCODER_IMM_CHECK_EN.
module inst_pack
  import inst_pkg::*;
(
  input  logic [6:0]  i_opcode,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs,
  input  logic [4:0]  i_rs2,
  input  logic [2:0]  i_funct3,
  input  logic [6:0]  i_funct7,
  input  logic [31:0] i_imm,
  output fmt_t        o_fmt,
  output logic [31:0] o_word,
  output logic        o_imm_ok
);

  logic w_shift;

  // slli/srli/srai carry funct7 in the upper immediate bits
  assign w_shift = (i_opcode == OP_IMM) && (i_funct3[1:0] == 2'b01);
  assign o_fmt   = fmt_of(i_opcode);

  always_comb begin
    o_word = '0;
    case (o_fmt)
      FMT_R: o_word = {i_funct7, i_rs2, i_rs, i_funct3, i_rd, i_opcode};
      FMT_I: begin
        if (w_shift)
          o_word = {i_funct7, i_imm[4:0], i_rs, i_funct3, i_rd, i_opcode};
        else
          o_word = {i_imm[11:0], i_rs, i_funct3, i_rd, i_opcode};
      end
      FMT_S: o_word = {i_imm[11:5], i_rs2, i_rs, i_funct3, i_imm[4:0], i_opcode};
      FMT_B: o_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs, i_funct3,
                       i_imm[4:1], i_imm[11], i_opcode};
      FMT_U: o_word = {i_imm[31:12], i_rd, i_opcode};
      FMT_J: o_word = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
      default: o_word = '0;
    endcase
  end

`ifdef INST_ENCODER_IMM_CHECK_EN
  logic w_fit12;
  logic w_fit13;
  logic w_fit21;

  // a signed value fits in N bits when bits [31:N-1] are all copies of the sign
  assign w_fit12 = (&i_imm[31:11]) || !(|i_imm[31:11]);
  assign w_fit13 = (&i_imm[31:12]) || !(|i_imm[31:12]);
  assign w_fit21 = (&i_imm[31:20]) || !(|i_imm[31:20]);

  always_comb begin
    o_imm_ok = 1'b1;
    case (o_fmt)
      FMT_I, FMT_S: o_imm_ok = w_fit12;
      FMT_B:        o_imm_ok = w_fit13 && !i_imm[0];
      FMT_J:        o_imm_ok = w_fit21 && !i_imm[0];
      FMT_U:        o_imm_ok = (i_imm[11:0] == 12'd0);
      default:      o_imm_ok = 1'b1;
    endcase
  end
`else
  assign o_imm_ok = 1'b1;
`endif

endmodule

// File: rtl/inst_encoder.sv
// rtl/inst_encoder.sv - RV32I field encoder streaming words to instruction memory
// Optional immediate range check: INST_ENCODER_IMM_CHECK_EN.
module inst_encoder
  import inst_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_data,
  output logic              full,
  output logic              err_illegal,
  output logic              err_imm
);

  localparam logic [ADDR_W-1:0] LP_BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LP_LAST = {ADDR_W{1'b1}};

  fmt_t              w_fmt;
  logic [31:0]       w_word;
  logic              w_imm_ok;
  logic              w_in_xfer;
  logic              w_legal;
  logic              w_accept;
  logic              w_out_xfer;

  logic              r_main_valid;
  logic [31:0]       r_main_data;
  logic [ADDR_W-1:0] r_main_addr;
  logic              r_skid_valid;
  logic [31:0]       r_skid_data;
  logic [ADDR_W-1:0] r_skid_addr;
  logic [ADDR_W-1:0] r_addr;
  logic              r_full;
  logic              r_err_illegal;

  inst_pack u_pack (
    .i_opcode (opcode),
    .i_rd     (rd),
    .i_rs     (rs),
    .i_rs2    (rs2),
    .i_funct3 (funct3),
    .i_funct7 (funct7),
    .i_imm    (imm),
    .o_fmt    (w_fmt),
    .o_word   (w_word),
    .o_imm_ok (w_imm_ok)
  );

  // in_ready depends only on registered state, never on out_ready
  assign in_ready   = !r_full && !r_skid_valid;
  assign w_in_xfer  = in_valid && in_ready;
  assign w_legal    = (w_fmt != FMT_ILL);
  assign w_accept   = w_in_xfer && w_legal && w_imm_ok;
  assign w_out_xfer = r_main_valid && out_ready;

  assign out_valid   = r_main_valid;
  assign out_data    = r_main_data;
  assign out_addr    = r_main_addr;
  assign full        = r_full;
  assign err_illegal = r_err_illegal;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_main_valid  <= 1'b0;
      r_main_data   <= '0;
      r_main_addr   <= '0;
      r_skid_valid  <= 1'b0;
      r_skid_data   <= '0;
      r_skid_addr   <= '0;
      r_addr        <= LP_BASE;
      r_full        <= 1'b0;
      r_err_illegal <= 1'b0;
    end else begin
      r_err_illegal <= w_in_xfer && !w_legal;
      if (w_accept) begin
        if (r_addr == LP_LAST) r_full <= 1'b1;
        else                   r_addr <= r_addr + ADDR_W'(1);
      end
      // skid is only ever occupied behind a valid main entry, and blocks new input
      if (w_out_xfer || !r_main_valid) begin
        if (r_skid_valid) begin
          r_main_data  <= r_skid_data;
          r_main_addr  <= r_skid_addr;
          r_skid_valid <= 1'b0;
        end else begin
          r_main_valid <= w_accept;
          if (w_accept) begin
            r_main_data <= w_word;
            r_main_addr <= r_addr;
          end
        end
      end else if (w_accept) begin
        r_skid_valid <= 1'b1;
        r_skid_data  <= w_word;
        r_skid_addr  <= r_addr;
      end
    end
  end

`ifdef INST_ENCODER_IMM_CHECK_EN
  logic r_err_imm;

  always_ff @(posedge clk) begin
    if (rst || clear) r_err_imm <= 1'b0;
    else              r_err_imm <= w_in_xfer && w_legal && !w_imm_ok;
  end

  assign err_imm = r_err_imm;
`else
  assign err_imm = 1'b0;
`endif

endmodule
